// File: rtl/inst_cache_if.sv
// Fetch, snoop and refill signals of the instruction cache, grouped for port use.
// Signal suffixes are relative to the cache; slave is the cache side, master the surrounding system.
interface inst_cache_if;
  logic        req_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        snoop_we_i;
  logic [31:0] snoop_addr_i;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        cache_hit_o;
  logic [31:0] cache_inst_o;
  logic        stall_o;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  modport slave (
    input  req_i, pc_i, flush_i, snoop_we_i, snoop_addr_i, mem_rdata_i, mem_ready_i,
    output mem_req_o, mem_addr_o, cache_hit_o, cache_inst_o, stall_o, hit_cnt_o, miss_cnt_o
  );

  modport master (
    output req_i, pc_i, flush_i, snoop_we_i, snoop_addr_i, mem_rdata_i, mem_ready_i,
    input  mem_req_o, mem_addr_o, cache_hit_o, cache_inst_o, stall_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache with zero-latency hit, single-word refill,
// flush and store-snoop invalidation. Define ICACHE_STATS_EN to build the hit/miss counters.
module inst_cache #(
  parameter int unsigned INDEX_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  inst_cache_if.slave  bus
);

  localparam int unsigned LINES = 32'(1) << INDEX_W;
  localparam int unsigned TAG_W = 30 - INDEX_W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic                abort_q, abort_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  logic [INDEX_W-1:0]  idx, snoop_idx, fill_idx;
  logic [TAG_W-1:0]    pc_tag, snoop_tag;
  logic                hit_c;
  logic                miss_c;
  logic                fill_done_c;
  logic                snoop_line_c;
  logic                snoop_fill_c;
  logic                kill_c;
  logic                unused_addr_bits;

  assign idx       = bus.pc_i[INDEX_W+1:2];
  assign pc_tag    = bus.pc_i[31:INDEX_W+2];
  assign snoop_idx = bus.snoop_addr_i[INDEX_W+1:2];
  assign snoop_tag = bus.snoop_addr_i[31:INDEX_W+2];
  assign fill_idx  = mem_addr_q[INDEX_W+1:2];

  assign unused_addr_bits = ^{bus.pc_i[1:0], bus.snoop_addr_i[1:0]};

  // Lookup is combinational; a same-cycle flush suppresses the hit.
  assign hit_c = (state_q == IDLE) & bus.req_i & valid_q[idx]
               & (tag_q[idx] == pc_tag) & ~bus.flush_i;

  assign snoop_line_c = bus.snoop_we_i & (tag_q[snoop_idx] == snoop_tag);
  assign snoop_fill_c = bus.snoop_we_i & (state_q == FILL)
                      & (bus.snoop_addr_i[31:2] == mem_addr_q[31:2]);
  assign fill_done_c  = (state_q == FILL) & bus.mem_ready_i;
  assign kill_c       = abort_q | bus.flush_i | snoop_fill_c;

  assign bus.cache_hit_o  = hit_c;
  assign bus.cache_inst_o = data_q[idx];
  assign bus.stall_o      = bus.req_i & ~hit_c;
  assign bus.mem_req_o    = mem_req_q;
  assign bus.mem_addr_o   = mem_addr_q;

  // Next-state and refill-request logic.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    abort_d    = abort_q;
    miss_c     = 1'b0;
    case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (bus.req_i && !hit_c) begin
          state_d    = FILL;
          mem_req_d  = 1'b1;
          mem_addr_d = {bus.pc_i[31:2], 2'b00};
          miss_c     = 1'b1;
        end
      end
      FILL: begin
        if (bus.flush_i || snoop_fill_c) begin
          abort_d = 1'b1;
        end
        if (bus.mem_ready_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          abort_d   = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        abort_d   = 1'b0;
      end
    endcase
  end

  // Valid update: snoop first so a refill of a new tag is not cleared by the old tag's snoop,
  // then the refill (killed by any pending or same-cycle invalidation), then flush over all.
  always_comb begin
    valid_d = valid_q;
    if (snoop_line_c) begin
      valid_d[snoop_idx] = 1'b0;
    end
    if (fill_done_c) begin
      valid_d[fill_idx] = ~kill_c;
    end
    if (bus.flush_i) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      abort_q    <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      abort_q    <= abort_d;
      valid_q    <= valid_d;
    end
  end

  // Tag and data storage carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (fill_done_c && !rst) begin
      tag_q[fill_idx]  <= mem_addr_q[31:INDEX_W+2];
      data_q[fill_idx] <= bus.mem_rdata_i;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_c) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (miss_c) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_cnt_o  = hit_cnt_q;
  assign bus.miss_cnt_o = miss_cnt_q;
`else
  assign bus.hit_cnt_o  = '0;
  assign bus.miss_cnt_o = '0;
`endif

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter INDEX_W, default 5, meaning log2 of line count; one 32-bit word per line, 32 lines.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_i  input  1  fetch stage requests the instruction at pc_i.
REQ-005 pc_i  input  32  fetch address; bits [1:0] ignored.
REQ-006 flush_i  input  1  invalidate entire cache.
REQ-007 snoop_we_i  input  1  a data store is occurring this cycle.
REQ-008 snoop_addr_i  input  32  byte address of that store.
REQ-009 mem_rdata_i  input  32  refill word from instruction memory.
REQ-010 mem_ready_i  input  1  mem_rdata_i is valid this cycle.
REQ-011 mem_req_o  output  1  refill request, held until mem_ready_i.
REQ-012 mem_addr_o  output  32  word-aligned refill address.
REQ-013 cache_hit_o  output  1  cache_inst_o is valid for pc_i this cycle.
REQ-014 cache_inst_o  output  32  instruction word.
REQ-015 stall_o  output  1  fetch must hold its PC.
REQ-016 hit_cnt_o, miss_cnt_o  output  32 each  statistics counters; see Configuration.

Function
REQ-017 Index = pc_i[INDEX_W+1:2]; tag = pc_i[31:INDEX_W+2]; per line: valid bit, tag, data word.
REQ-018 States: IDLE, FILL.
REQ-019 In IDLE, cache_hit_o = req_i & valid[index] & tag match, combinational, zero-cycle latency; cache_inst_o = data[index].
REQ-020 In FILL, cache_hit_o = 0.
REQ-021 stall_o = req_i & ~cache_hit_o.
REQ-022 IDLE miss (req_i & ~hit) -> FILL next cycle; mem_addr_o latched to {pc_i[31:2],2'b00}; mem_req_o = 1 from that cycle.
REQ-023 In FILL, mem_req_o and mem_addr_o hold until a cycle with mem_ready_i = 1.
REQ-024 On that mem_ready_i cycle, the line is written: data = mem_rdata_i, tag, valid = 1; mem_req_o deasserts next cycle; -> IDLE.
REQ-025 Miss at cycle 0, ready at cycle k -> hit on the same pc_i at cycle k+1.
REQ-026 mem_ready_i in IDLE is ignored.
REQ-027 pc_i changes during FILL do not alter mem_addr_o; the new pc is looked up on return to IDLE.
REQ-028 flush_i clears all valid bits in one cycle and forces cache_hit_o = 0 in that cycle.
REQ-029 flush_i during FILL sets an abort flag: the fill completes its handshake, but the line is written with valid = 0; the flag clears on return to IDLE.
REQ-030 snoop_we_i clears valid of the line indexed by snoop_addr_i when its tag matches.
REQ-031 A snoop matching mem_addr_o during FILL sets the abort flag.
REQ-032 flush/snoop and refill write in the same cycle: invalidation wins.

Reset
REQ-033 rst: all valid = 0, state IDLE, abort flag = 0, mem_req_o = 0, mem_addr_o = 0, counters = 0.
REQ-034 rst mid-FILL abandons the refill immediately; a later mem_ready_i is ignored.
REQ-035 Tag and data arrays are not reset.

Configuration
REQ-036 Macro ICACHE_STATS_EN.
- Defined: hit_cnt_o increments on each IDLE cycle with cache_hit_o; miss_cnt_o increments on each IDLE->FILL transition; both are 32-bit, wrap at 2^32, and clear on rst.
- Undefined: both ports are tied to 0 and no counter logic exists.

Verification
REQ-037 After rst, req_i = 1, pc_i = 0x80000000 -> stall_o = 1; next cycle mem_req_o = 1, mem_addr_o = 0x80000000.
REQ-038 mem_ready_i = 1 with mem_rdata_i = 0x3C011234 after 3 FILL cycles -> next cycle cache_hit_o = 1, cache_inst_o = 0x3C011234, stall_o = 0.
REQ-039 Hit on 0x80000000, then access 0x80000080 (same index, different tag) -> miss and refill; then 0x80000000 misses again.
REQ-040 flush_i during FILL for 0x80000004, then ready -> line not valid; a re-request of 0x80000004 misses.
REQ-041 snoop_we_i = 1, snoop_addr_i = 0x80000000 on a valid line -> next access to 0x80000000 misses; a snoop to 0x80000080 leaves it valid.
REQ-042 With ICACHE_STATS_EN: 1 miss, then 4 hit cycles -> miss_cnt_o = 1, hit_cnt_o = 4; pulse rst -> both 0.
